// File: rtl/paddsub_reduce_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// paddsub_reduce_ctrl_pkg
// Shared definitions for the packed saturating reduction sequencer:
//   - state_e : FSM state encoding (IDLE / ACCUM / DONE)
//   - WORD_W  : packed operand / accumulator width
//   - LANE_W  : width of one signed lane inside the packed word
//   - LANES   : number of lanes per packed word
// ---------------------------------------------------------------------------
package paddsub_reduce_ctrl_pkg;

  localparam int WORD_W = 16;
  localparam int LANE_W = 4;
  localparam int LANES  = WORD_W / LANE_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/paddsub_reduce_ctrl_paddsub.sv
// ---------------------------------------------------------------------------
// paddsub_16bit
// Packed 4 x 4-bit signed adder with per-lane saturation. Lanes are fully
// independent: no carry crosses a lane boundary and no flags are produced.
// Ports:
//   a_in    [15:0] packed operand A (4 signed lanes)
//   b_in    [15:0] packed operand B (4 signed lanes)
//   sum_out [15:0] packed lane-wise saturated sum
// ---------------------------------------------------------------------------
module paddsub_16bit
  import paddsub_reduce_ctrl_pkg::*;
(
  input  logic [WORD_W-1:0] a_in,
  input  logic [WORD_W-1:0] b_in,
  output logic [WORD_W-1:0] sum_out
);

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    logic [LANE_W:0] lane_sum;

    // One guard bit: sign-extend both lanes so the 5-bit sum is exact.
    assign lane_sum = {a_in[gi*LANE_W+LANE_W-1], a_in[gi*LANE_W +: LANE_W]}
                    + {b_in[gi*LANE_W+LANE_W-1], b_in[gi*LANE_W +: LANE_W]};

    // Guard bit disagreeing with the lane sign bit means the exact sum is out
    // of the 4-bit range; the guard bit then gives the true sign to clamp to.
    assign sum_out[gi*LANE_W +: LANE_W] =
        (lane_sum[LANE_W] == lane_sum[LANE_W-1]) ? lane_sum[LANE_W-1:0]
      : (lane_sum[LANE_W] ? 4'b1000 : 4'b0111);
  end

endmodule

// File: rtl/paddsub_reduce_ctrl.sv
// ---------------------------------------------------------------------------
// paddsub_reduce_ctrl
// Sequencer folding a stream of packed 16-bit operand words into an
// accumulator using one lane-wise saturating adder (paddsub_16bit).
// Optional build macro: PADDSUB_SAT_FLAG_EN adds the sticky sat_seen output.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, cnt, init  command strobe (IDLE only), beat count, initial acc
//   abort             cancel an in-flight reduction (ACCUM only)
//   in_valid/in_ready operand stream handshake, in_data packed operand
//   busy              command in progress (ACCUM or DONE)
//   done              single-cycle completion pulse
//   result            last completed accumulator value
//   result_valid      result holds a completed reduction
//   sat_seen          (PADDSUB_SAT_FLAG_EN) any lane overflow in this command
// ---------------------------------------------------------------------------
module paddsub_reduce_ctrl
  import paddsub_reduce_ctrl_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  cnt,
  input  logic [WORD_W-1:0] init,
  input  logic              abort,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [WORD_W-1:0] result,
  output logic              result_valid
`ifdef PADDSUB_SAT_FLAG_EN
  ,
  output logic              sat_seen
`endif
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e            state_q;
  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_d;
  logic [CNT_W-1:0]  remaining_q;
  logic [WORD_W-1:0] result_q;
  logic              result_valid_q;
  logic              beat_accept;

  paddsub_16bit u_paddsub (
    .a_in    (acc_q),
    .b_in    (in_data),
    .sum_out (acc_d)
  );

  // Abort takes priority over a beat presented in the same cycle.
  assign beat_accept = (state_q == ST_ACCUM) && in_valid && !abort
                     && (remaining_q != '0);

`ifdef PADDSUB_SAT_FLAG_EN
  logic [LANES-1:0] lane_ovf;
  logic             sat_seen_q;

  // Raw (wrapping) lane sum overflows when both operands share a sign and
  // the wrapped result does not.
  for (genvar gi = 0; gi < LANES; gi++) begin : g_ovf
    logic [LANE_W-1:0] raw_sum;
    assign raw_sum      = acc_q[gi*LANE_W +: LANE_W] + in_data[gi*LANE_W +: LANE_W];
    assign lane_ovf[gi] = (acc_q[gi*LANE_W+LANE_W-1] == in_data[gi*LANE_W+LANE_W-1])
                       && (raw_sum[LANE_W-1] != acc_q[gi*LANE_W+LANE_W-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_seen_q <= 1'b0;
    end else if ((state_q == ST_IDLE) && start) begin
      sat_seen_q <= 1'b0;
    end else if (beat_accept && (|lane_ovf)) begin
      sat_seen_q <= 1'b1;
    end
  end

  assign sat_seen = sat_seen_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      acc_q          <= '0;
      remaining_q    <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            acc_q       <= init;
            remaining_q <= cnt;
            if (cnt == '0) begin
              // Empty reduction: result must already show init during DONE.
              state_q        <= ST_DONE;
              result_q       <= init;
              result_valid_q <= 1'b1;
            end else begin
              state_q        <= ST_ACCUM;
              result_valid_q <= 1'b0;
            end
          end
        end
        ST_ACCUM: begin
          if (abort) begin
            state_q        <= ST_IDLE;
            acc_q          <= '0;
            remaining_q    <= '0;
            result_valid_q <= 1'b0;
          end else if (beat_accept) begin
            acc_q       <= acc_d;
            remaining_q <= remaining_q - CNT_ONE;
            if (remaining_q == CNT_ONE) begin
              // Publish on the accepting edge so result is visible in DONE.
              state_q        <= ST_DONE;
              result_q       <= acc_d;
              result_valid_q <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready     = (state_q == ST_ACCUM);
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign result       = result_q;
  assign result_valid = result_valid_q;

endmodule

// File: tb/tb_paddsub_reduce_ctrl.sv
// ---------------------------------------------------------------------------
// tb_paddsub_reduce_ctrl
// Self-checking bench: directed scenarios plus randomized commands, compared
// against an integer-arithmetic model of lane-wise saturating addition.
// ---------------------------------------------------------------------------
module tb_paddsub_reduce_ctrl;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] cnt = '0;
  logic [15:0]      init_v = '0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic [15:0]      in_data = '0;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic [15:0]      result;
  logic             result_valid;
`ifdef PADDSUB_SAT_FLAG_EN
  logic             sat_seen;
`endif

  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [15:0] exp_result = '0;
  logic        exp_rv = 1'b0;
  logic        exp_sat = 1'b0;
  logic [15:0] beats[$];

  paddsub_reduce_ctrl #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .cnt          (cnt),
    .init         (init_v),
    .abort        (abort),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .busy         (busy),
    .done         (done),
    .result       (result),
    .result_valid (result_valid)
`ifdef PADDSUB_SAT_FLAG_EN
    ,
    .sat_seen     (sat_seen)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Signed value of lane i of a packed word.
  function automatic int lane(input logic [15:0] w, input int i);
    int v;
    v = int'((w >> (4 * i)) & 16'h000F);
    if (v > 7) v -= 16;
    return v;
  endfunction

  function automatic logic [15:0] ref_add(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    int s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s = lane(a, i) + lane(b, i);
      if (s > 7) s = 7;
      if (s < -8) s = -8;
      r[4*i +: 4] = s[3:0];
    end
    return r;
  endfunction

  function automatic logic ref_ovf(input logic [15:0] a, input logic [15:0] b);
    int s;
    logic o;
    o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s = lane(a, i) + lane(b, i);
      if (s > 7 || s < -8) o = 1'b1;
    end
    return o;
  endfunction

  task automatic check_sat(input string tag);
`ifdef PADDSUB_SAT_FLAG_EN
    chk(tag, 32'(sat_seen), 32'(exp_sat));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // One command: beats[] supplies the operands; abort_at = beat index on
  // which abort is raised (-1 for none); noise pulses start during stalls
  // and start/abort during DONE, all of which must be ignored.
  task automatic run_cmd(input int n, input logic [15:0] iv, input int min_gap,
                         input int max_gap, input int abort_at, input bit noise);
    logic [15:0] acc;
    logic        sat;
    int          d0;
    int          gap;
    tick();
    start  = 1'b1;
    cnt    = n[CNT_W-1:0];
    init_v = iv;
    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_ready", 32'(in_ready), 32'(0));
    tick();
    start = 1'b0;
    acc = iv;
    sat = 1'b0;
    d0  = done_cnt;
    for (int k = 0; k < n; k++) begin
      gap = int'($urandom_range(max_gap, min_gap));
      for (int g = 0; g < gap; g++) begin
        in_valid = 1'b0;
        if (noise) begin
          start  = 1'b1;
          cnt    = 8'($urandom);
          init_v = 16'($urandom);
        end
        @(negedge clk);
        chk("stall_ready", 32'(in_ready), 32'(1));
        chk("stall_busy", 32'(busy), 32'(1));
        chk("stall_done", 32'(done), 32'(0));
        tick();
        start = 1'b0;
      end
      in_valid = 1'b1;
      in_data  = beats[k];
      abort    = (k == abort_at);
      @(negedge clk);
      chk("beat_ready", 32'(in_ready), 32'(1));
      tick();
      in_valid = 1'b0;
      if (k == abort_at) begin
        abort   = 1'b0;
        exp_rv  = 1'b0;
        exp_sat = sat;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 32'(0));
        chk("abort_ready", 32'(in_ready), 32'(0));
        chk("abort_rv", 32'(result_valid), 32'(0));
        chk("abort_result", 32'(result), 32'(exp_result));
        chk("abort_nodone", 32'(done_cnt - d0), 32'(0));
        check_sat("abort_sat");
        $display("cmd n=%0d init=%h aborted at beat %0d", n, iv, k);
        return;
      end
      sat = sat | ref_ovf(acc, beats[k]);
      acc = ref_add(acc, beats[k]);
    end
    exp_result = acc;
    exp_rv     = 1'b1;
    exp_sat    = sat;
    if (noise) begin
      abort = 1'b1;
      start = 1'b1;
    end
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'(1));
    chk("done_busy", 32'(busy), 32'(1));
    chk("done_ready", 32'(in_ready), 32'(0));
    chk("done_result", 32'(result), 32'(exp_result));
    chk("done_rv", 32'(result_valid), 32'(1));
    check_sat("done_sat");
    tick();
    abort = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("after_done", 32'(done), 32'(0));
    chk("after_busy", 32'(busy), 32'(0));
    chk("hold_result", 32'(result), 32'(exp_result));
    chk("hold_rv", 32'(result_valid), 32'(1));
    chk("one_done", 32'(done_cnt - d0), 32'(1));
    check_sat("hold_sat");
    $display("cmd n=%0d init=%h result=%h", n, iv, result);
  endtask

  initial begin
    int n;
    int ab;
    #2;
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(in_ready), 32'(0));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_rv", 32'(result_valid), 32'(0));
    check_sat("rst_sat");
    tick();
    rst_n = 1'b1;

    // Basic sum
    beats = '{16'h1234, 16'h1111};
    run_cmd(2, 16'h0000, 0, 0, -1, 1'b0);
    chk("plan_basic", 32'(result), 32'h2345);
    // Positive saturation
    beats = '{16'h4444, 16'h4444, 16'h4444};
    run_cmd(3, 16'h0000, 0, 0, -1, 1'b0);
    chk("plan_possat", 32'(result), 32'h7777);
    // Negative saturation
    beats = '{16'hFFF0};
    run_cmd(1, 16'h8880, 0, 0, -1, 1'b0);
    chk("plan_negsat", 32'(result), 32'h8880);
    // Zero count
    beats = '{};
    run_cmd(0, 16'hABCD, 0, 0, -1, 1'b0);
    chk("plan_zero", 32'(result), 32'hABCD);
    // Stalls with ignored start (and ignored start/abort in DONE)
    beats = '{16'h0101, 16'h0202};
    run_cmd(2, 16'h0000, 3, 3, -1, 1'b1);
    chk("plan_stall", 32'(result), 32'h0303);
    // Abort after the first accept
    beats = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
    run_cmd(4, 16'h0000, 0, 1, 1, 1'b0);

    // Randomized commands
    for (int c = 0; c < 30; c++) begin
      n = int'($urandom_range(6, 0));
      beats = '{};
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(1, 0) == 0) beats.push_back(16'($urandom));
        else beats.push_back({4{4'($urandom_range(15, 12))}} ^ 16'($urandom_range(3, 0)));
      end
      ab = (n > 0 && $urandom_range(4, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      run_cmd(n, 16'($urandom), 0, 3, ab, 1'($urandom));
    end

    // Make result nonzero, then reset asynchronously mid-ACCUM
    beats = '{16'h1357};
    run_cmd(1, 16'h2222, 0, 0, -1, 1'b0);
    tick();
    start  = 1'b1;
    cnt    = 8'd4;
    init_v = 16'h1111;
    tick();
    start    = 1'b0;
    in_valid = 1'b1;
    in_data  = 16'h1111;
    tick();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_ready", 32'(in_ready), 32'(0));
    chk("arst_done", 32'(done), 32'(0));
    chk("arst_result", 32'(result), 32'(0));
    chk("arst_rv", 32'(result_valid), 32'(0));
    exp_sat = 1'b0;
    check_sat("arst_sat");
    tick();
    rst_n = 1'b1;
    exp_result = '0;
    exp_rv     = 1'b0;
    $display("cmd async reset mid-ACCUM");

    beats = '{16'h7001, 16'h0999};
    run_cmd(2, 16'h0000, 0, 2, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
